// File: rtl/frame_reader_pkg.sv
// Shared types and constants for the Wishbone frame reader.
//   pixel_t      : 24-bit RGB pixel
//   fifo_entry_t : output buffer entry {data, sof, eol}
//   wb_state_t   : Wishbone master request state
package frame_reader_pkg;

  typedef logic [23:0] pixel_t;

  typedef struct packed {
    pixel_t data;
    logic   sof;
    logic   eol;
  } fifo_entry_t;

  typedef enum logic {
    WB_IDLE,
    WB_REQ
  } wb_state_t;

  localparam logic [3:0] WSHB_SEL_ALL = 4'hF;
  localparam logic [2:0] CTI_CLASSIC  = 3'b000;
  localparam logic [1:0] BTE_LINEAR   = 2'b00;

  // Counter width that never collapses to zero bits.
  function automatic int unsigned clog2_min1(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/wshb_if.sv
// Wishbone B4 classic bus, 32-bit data, byte addresses.
//   master modport : drives cyc/stb/we/adr/sel/cti/bte/dat_ms, samples dat_sm/ack/err/rty
//   slave  modport : the reverse
interface wshb_if;

  logic [31:0] adr;
  logic [31:0] dat_ms;
  logic [31:0] dat_sm;
  logic [3:0]  sel;
  logic [2:0]  cti;
  logic [1:0]  bte;
  logic        cyc;
  logic        stb;
  logic        we;
  logic        ack;
  logic        err;
  logic        rty;

  modport master (
    output adr, dat_ms, sel, cti, bte, cyc, stb, we,
    input  dat_sm, ack, err, rty
  );

  modport slave (
    input  adr, dat_ms, sel, cti, bte, cyc, stb, we,
    output dat_sm, ack, err, rty
  );

endinterface

// File: rtl/pix_sync_fifo.sv
// Single-clock show-ahead FIFO of fifo_entry_t with registered head and count.
//   sys_clk, sys_rst : clock, synchronous active-high reset
//   push, din        : write request and entry (ignored when full)
//   pop              : consume head (ignored when empty)
//   dout, valid      : registered head entry, non-empty flag
//   count            : number of stored entries
module pix_sync_fifo
  import frame_reader_pkg::*;
#(
  parameter int unsigned DEPTH = 8,
  localparam int unsigned AW   = clog2_min1(DEPTH),
  localparam int unsigned CW   = AW + 1
) (
  input  logic          sys_clk,
  input  logic          sys_rst,
  input  logic          push,
  input  fifo_entry_t   din,
  input  logic          pop,
  output fifo_entry_t   dout,
  output logic          valid,
  output logic [CW-1:0] count
);

  fifo_entry_t   mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr, wr_ptr_n, rd_ptr_n;
  logic [CW-1:0] count_n;
  logic          do_push, do_pop;
  fifo_entry_t   head_n;

  assign do_push = push && (count != CW'(DEPTH));
  assign do_pop  = pop && (count != '0);

  // Next head: a write landing on the new read slot bypasses the array.
  always_comb begin
    wr_ptr_n = do_push ? wr_ptr + AW'(1) : wr_ptr;
    rd_ptr_n = do_pop  ? rd_ptr + AW'(1) : rd_ptr;
    count_n  = count + CW'(do_push) - CW'(do_pop);
    head_n   = '0;
    if (count_n != '0) begin
      if (do_push && (wr_ptr == rd_ptr_n)) head_n = din;
      else                                 head_n = mem[rd_ptr_n];
    end
  end

  // Storage array, no reset needed.
  always_ff @(posedge sys_clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

  // Pointers, count and registered head.
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      dout   <= '0;
      valid  <= 1'b0;
    end else begin
      wr_ptr <= wr_ptr_n;
      rd_ptr <= rd_ptr_n;
      count  <= count_n;
      dout   <= head_n;
      valid  <= (count_n != '0);
    end
  end

endmodule

// File: rtl/wshb_frame_reader.sv
// Reads a HDISP x VDISP frame of 32-bit words from SDRAM with Wishbone classic
// single reads and streams the pixels out through a show-ahead buffer.
//   sys_clk, sys_rst        : clock, synchronous active-high reset
//   wshb_ifm                : Wishbone master towards SDRAM
//   pix_data/valid/sof/eol  : stream output, sof at (0,0), eol at x=HDISP-1
//   pix_ready               : stream consumer accept
// Build option FRAME_READER_PATTERN_EN: bus held idle, buffer filled with an
// internal {x, y, x^y} test pattern instead of SDRAM data.
module wshb_frame_reader
  import frame_reader_pkg::*;
#(
  parameter int unsigned HDISP      = 800,
  parameter int unsigned VDISP      = 480,
  parameter logic [31:0] BASE_ADDR  = 32'h0,
  parameter int unsigned FIFO_DEPTH = 8
) (
  input  logic          sys_clk,
  input  logic          sys_rst,
  wshb_if.master        wshb_ifm,
  output logic [23:0]   pix_data,
  output logic          pix_valid,
  input  logic          pix_ready,
  output logic          pix_sof,
  output logic          pix_eol
);

  localparam int unsigned XW = clog2_min1(HDISP);
  localparam int unsigned YW = clog2_min1(VDISP);
  localparam int unsigned IW = clog2_min1(HDISP * VDISP);
  localparam int unsigned CW = clog2_min1(FIFO_DEPTH) + 1;
  localparam int unsigned NW = CW + 1;

  logic [XW-1:0] x_q, x_n;
  logic [YW-1:0] y_q, y_n;
  logic [IW-1:0] idx_q, idx_n;
  logic          last_x, last_y;

  fifo_entry_t   push_entry, head;
  pixel_t        pix_rgb;
  logic          push, pop, room;
  logic [CW-1:0] fifo_count;
  logic [NW-1:0] cnt_next;

  // Raster position of the pixel being fetched and its successor.
  always_comb begin
    last_x = (x_q == XW'(HDISP - 1));
    last_y = (y_q == YW'(VDISP - 1));
    x_n    = last_x ? '0 : x_q + XW'(1);
    y_n    = y_q;
    if (last_x) y_n = last_y ? '0 : y_q + YW'(1);
    idx_n  = (last_x && last_y) ? '0 : idx_q + IW'(1);
  end

  always_comb begin
    push_entry      = '0;
    push_entry.data = pix_rgb;
    push_entry.sof  = (x_q == '0) && (y_q == '0);
    push_entry.eol  = last_x;
  end

  // Occupancy after this edge; a request is only issued when its reply fits.
  assign pop      = pix_valid && pix_ready;
  assign cnt_next = NW'(fifo_count) + NW'(push) - NW'(pop);
  assign room     = cnt_next < NW'(FIFO_DEPTH);

  pix_sync_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .sys_clk (sys_clk),
    .sys_rst (sys_rst),
    .push    (push),
    .din     (push_entry),
    .pop     (pop),
    .dout    (head),
    .valid   (pix_valid),
    .count   (fifo_count)
  );

  assign pix_data = head.data;
  assign pix_sof  = head.sof;
  assign pix_eol  = head.eol;

`ifdef FRAME_READER_PATTERN_EN

  logic unused_pat;

  assign push    = (fifo_count != CW'(FIFO_DEPTH));
  assign pix_rgb = {8'(x_q), 8'(y_q), 8'(x_q) ^ 8'(y_q)};

  assign wshb_ifm.cyc    = 1'b0;
  assign wshb_ifm.stb    = 1'b0;
  assign wshb_ifm.we     = 1'b0;
  assign wshb_ifm.adr    = BASE_ADDR;
  assign wshb_ifm.sel    = WSHB_SEL_ALL;
  assign wshb_ifm.cti    = CTI_CLASSIC;
  assign wshb_ifm.bte    = BTE_LINEAR;
  assign wshb_ifm.dat_ms = '0;

  assign unused_pat = ^{wshb_ifm.dat_sm, wshb_ifm.ack, wshb_ifm.err,
                        wshb_ifm.rty, room};

  // Pattern generator walks the raster one entry per cycle while not full.
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      x_q   <= '0;
      y_q   <= '0;
      idx_q <= '0;
    end else if (push) begin
      x_q   <= x_n;
      y_q   <= y_n;
      idx_q <= idx_n;
    end
  end

`else

  wb_state_t   state_q;
  logic        cyc_q, stb_q;
  logic [31:0] adr_q;
  logic        done;
  logic        unused_wb;

  function automatic logic [31:0] addr_of(input logic [IW-1:0] i);
    return BASE_ADDR + (32'(i) << 2);
  endfunction

  // err still consumes the pixel slot (black) so the frame keeps moving; rty does not.
  assign done    = (state_q == WB_REQ) && (wshb_ifm.ack || wshb_ifm.err || wshb_ifm.rty);
  assign push    = (state_q == WB_REQ) && (wshb_ifm.ack || wshb_ifm.err);
  assign pix_rgb = wshb_ifm.ack ? wshb_ifm.dat_sm[23:0] : '0;

  assign wshb_ifm.cyc    = cyc_q;
  assign wshb_ifm.stb    = stb_q;
  assign wshb_ifm.adr    = adr_q;
  assign wshb_ifm.we     = 1'b0;
  assign wshb_ifm.sel    = WSHB_SEL_ALL;
  assign wshb_ifm.cti    = CTI_CLASSIC;
  assign wshb_ifm.bte    = BTE_LINEAR;
  assign wshb_ifm.dat_ms = '0;

  assign unused_wb = ^wshb_ifm.dat_sm[31:24];

  // Request FSM; back-to-back requests when the buffer still has room.
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      state_q <= WB_IDLE;
      cyc_q   <= 1'b0;
      stb_q   <= 1'b0;
      adr_q   <= BASE_ADDR;
      x_q     <= '0;
      y_q     <= '0;
      idx_q   <= '0;
    end else begin
      case (state_q)
        WB_IDLE: begin
          if (room) begin
            state_q <= WB_REQ;
            cyc_q   <= 1'b1;
            stb_q   <= 1'b1;
          end
        end
        WB_REQ: begin
          if (done) begin
            if (push) begin
              x_q   <= x_n;
              y_q   <= y_n;
              idx_q <= idx_n;
              adr_q <= addr_of(idx_n);
            end
            if (!room) begin
              state_q <= WB_IDLE;
              cyc_q   <= 1'b0;
              stb_q   <= 1'b0;
            end
          end
        end
        default: begin
          state_q <= WB_IDLE;
          cyc_q   <= 1'b0;
          stb_q   <= 1'b0;
        end
      endcase
    end
  end

`endif

endmodule

// File: tb/tb_wshb_frame_reader.sv
// Directed bench for wshb_frame_reader with a 4x2 frame at 0x100 and an
// 8-entry buffer; the slave model acks one cycle after it sees a request.
module tb_wshb_frame_reader;

  typedef struct {
    logic [31:0] adr;
    logic [23:0] data;
    logic        sof;
    logic        eol;
  } vec_t;

  logic        sys_clk = 1'b0;
  logic        sys_rst = 1'b1;
  logic        pix_ready = 1'b0;
  logic [23:0] pix_data;
  logic        pix_valid, pix_sof, pix_eol;

  wshb_if wb();

  wshb_frame_reader #(
    .HDISP(4), .VDISP(2), .BASE_ADDR(32'h100), .FIFO_DEPTH(8)
  ) dut (
    .sys_clk   (sys_clk),
    .sys_rst   (sys_rst),
    .wshb_ifm  (wb),
    .pix_data  (pix_data),
    .pix_valid (pix_valid),
    .pix_ready (pix_ready),
    .pix_sof   (pix_sof),
    .pix_eol   (pix_eol)
  );

  always #5 sys_clk = ~sys_clk;

  int errors = 0;
  int checks = 0;
  vec_t tbl [8];

  logic [31:0] adr_log [$];
  vec_t        pix_log [$];
  int          ack_cnt = 0;
  int          cyc_seen = 0;

  logic [31:0] rty_adr = 32'h0, err_adr = 32'h0;
  int rty_req = 0, rty_srv = 0, err_req = 0, err_srv = 0;

  // Slave: one response per request cycle, one-shot rty/err on armed addresses.
  always @(posedge sys_clk) begin
    wb.ack <= 1'b0;
    wb.err <= 1'b0;
    wb.rty <= 1'b0;
    if (wb.cyc && wb.stb && !(wb.ack || wb.err || wb.rty)) begin
      if (rty_req != rty_srv && wb.adr == rty_adr) begin
        wb.rty  <= 1'b1;
        rty_srv <= rty_req;
      end else if (err_req != err_srv && wb.adr == err_adr) begin
        wb.err    <= 1'b1;
        wb.dat_sm <= 32'hFFFF_FFFF;
        err_srv   <= err_req;
      end else begin
        wb.ack    <= 1'b1;
        wb.dat_sm <= {8'hFF, 8'h00, wb.adr[15:0]};
      end
    end
  end

  // Monitor: responses and stream beats that complete at the next rising edge.
  always @(negedge sys_clk) begin
    if (!sys_rst) begin
      if (wb.cyc === 1'b1) cyc_seen++;
      if (wb.cyc && wb.stb && (wb.ack || wb.err || wb.rty)) adr_log.push_back(wb.adr);
      if (wb.cyc && wb.stb && wb.ack) ack_cnt++;
      if (pix_valid && pix_ready)
        pix_log.push_back(vec_t'{32'(pix_log.size()), pix_data, pix_sof, pix_eol});
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic chk_pix(input string name, input int k, input vec_t exp);
    vec_t got;
    got = (k < pix_log.size()) ? pix_log[k] : vec_t'{32'h0, 24'hxxxxxx, 1'bx, 1'bx};
    chk($sformatf("%s pix%0d {data,sof,eol}", name, k),
        32'({got.data, got.sof, got.eol}), 32'({exp.data, exp.sof, exp.eol}));
  endtask

  task automatic wait_pixels(input string name, input int n);
    int t;
    t = 0;
    while (pix_log.size() < n && t < 500) begin
      @(negedge sys_clk);
      t++;
    end
    if (pix_log.size() < n) begin
      checks++;
      errors++;
      $display("FAIL %s timeout: got %0d pixels, expected %0d", name, pix_log.size(), n);
    end
  endtask

  task automatic do_reset();
    @(posedge sys_clk);
    #1 sys_rst = 1'b1;
    repeat (2) @(posedge sys_clk);
    #1 sys_rst = 1'b0;
    adr_log.delete();
    pix_log.delete();
    ack_cnt = 0;
  endtask

  initial begin
`ifdef FRAME_READER_PATTERN_EN
    tbl[0] = '{32'd0, 24'h000000, 1'b1, 1'b0};
    tbl[1] = '{32'd1, 24'h010001, 1'b0, 1'b0};
    tbl[2] = '{32'd2, 24'h020002, 1'b0, 1'b0};
    tbl[3] = '{32'd3, 24'h030003, 1'b0, 1'b1};
    tbl[4] = '{32'd4, 24'h000101, 1'b0, 1'b0};
    tbl[5] = '{32'd5, 24'h010100, 1'b0, 1'b0};
    tbl[6] = '{32'd6, 24'h020103, 1'b0, 1'b0};
    tbl[7] = '{32'd7, 24'h030102, 1'b0, 1'b1};
`else
    tbl[0] = '{32'h100, 24'h000100, 1'b1, 1'b0};
    tbl[1] = '{32'h104, 24'h000104, 1'b0, 1'b0};
    tbl[2] = '{32'h108, 24'h000108, 1'b0, 1'b0};
    tbl[3] = '{32'h10C, 24'h00010C, 1'b0, 1'b1};
    tbl[4] = '{32'h110, 24'h000110, 1'b0, 1'b0};
    tbl[5] = '{32'h114, 24'h000114, 1'b0, 1'b0};
    tbl[6] = '{32'h118, 24'h000118, 1'b0, 1'b0};
    tbl[7] = '{32'h11C, 24'h00011C, 1'b0, 1'b1};
`endif

    // Reset values
    repeat (2) @(posedge sys_clk);
    @(negedge sys_clk);
    chk("reset cyc", 32'(wb.cyc), 32'd0);
    chk("reset stb", 32'(wb.stb), 32'd0);
    chk("reset adr", wb.adr, 32'h100);
    chk("reset pix_valid", 32'(pix_valid), 32'd0);
    chk("reset pix_data", 32'(pix_data), 32'd0);
    chk("reset pix_sof", 32'(pix_sof), 32'd0);
    chk("reset pix_eol", 32'(pix_eol), 32'd0);

`ifdef FRAME_READER_PATTERN_EN
    pix_ready = 1'b1;
    do_reset();
    wait_pixels("pattern", 16);
    for (int k = 0; k < 16; k++) chk_pix("pattern", k, tbl[k % 8]);
    repeat (50) @(negedge sys_clk);
    chk("pattern cyc never high", 32'(cyc_seen), 32'd0);
`else
    // Free-running stream with ready held high
    pix_ready = 1'b1;
    do_reset();
    wait_pixels("stream", 16);
    for (int k = 0; k < 16; k++) chk_pix("stream", k, tbl[k % 8]);
    chk("stream adr_log depth", 32'(adr_log.size() >= 9), 32'd1);
    for (int i = 0; i < 9 && i < adr_log.size(); i++)
      chk($sformatf("stream adr%0d", i), adr_log[i], tbl[i % 8].adr);

    // Back-pressure: buffer fills to depth, head held
    begin
      logic [25:0] head0;
      pix_ready = 1'b0;
      do_reset();
      repeat (4) @(negedge sys_clk);
      head0 = {pix_data, pix_sof, pix_eol};
      repeat (16) @(negedge sys_clk);
      chk("stall ack count", 32'(ack_cnt), 32'd8);
      chk("stall stb low", 32'(wb.stb), 32'd0);
      chk("stall head held", 32'({pix_data, pix_sof, pix_eol}), 32'(head0));
      chk("stall head value", 32'(head0), 32'({tbl[0].data, tbl[0].sof, tbl[0].eol}));
      @(posedge sys_clk);
      #1 pix_ready = 1'b1;
      wait_pixels("stall release", 8);
      for (int k = 0; k < 8; k++) chk_pix("stall release", k, tbl[k]);
    end

    // Retry on 0x108 reissues the same address
    rty_adr = 32'h108;
    rty_req++;
    do_reset();
    wait_pixels("rty", 8);
    chk("rty adr2", adr_log[2], 32'h108);
    chk("rty adr3", adr_log[3], 32'h108);
    chk("rty adr4", adr_log[4], 32'h10C);
    for (int k = 0; k < 8; k++) chk_pix("rty", k, tbl[k]);

    // Bus error on 0x10C yields a black pixel and the frame moves on
    err_adr = 32'h10C;
    err_req++;
    do_reset();
    wait_pixels("err", 8);
    chk("err adr after", adr_log[4], 32'h110);
    for (int k = 0; k < 8; k++) begin
      if (k == 3) chk_pix("err", k, vec_t'{32'h10C, 24'h000000, 1'b0, 1'b1});
      else        chk_pix("err", k, tbl[k]);
    end

    // Reset landing on an ack at 0x114
    begin
      int t;
      do_reset();
      t = 0;
      while (!(wb.stb === 1'b1 && wb.adr == 32'h114 && wb.ack === 1'b1) && t < 200) begin
        @(negedge sys_clk);
        t++;
      end
      chk("midreset reached 0x114 ack", 32'(t < 200), 32'd1);
      sys_rst = 1'b1;
      @(posedge sys_clk);
      #1 sys_rst = 1'b0;
      adr_log.delete();
      pix_log.delete();
      @(negedge sys_clk);
      chk("midreset pix_valid", 32'(pix_valid), 32'd0);
      chk("midreset cyc", 32'(wb.cyc), 32'd0);
      wait_pixels("midreset", 2);
      chk("midreset first adr", adr_log[0], 32'h100);
      chk_pix("midreset", 0, tbl[0]);
      chk_pix("midreset", 1, tbl[1]);
    end
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/wshb_frame_reader.md
WSHB_FRAME_READER -- requirements
Module: wshb_frame_reader

Interface
REQ-001 SHALL have parameter HDISP, default 800, meaning active pixels per line.
REQ-002 SHALL have parameter VDISP, default 480, meaning active lines per frame.
REQ-003 SHALL have parameter BASE_ADDR, default 32'h0, meaning byte address of pixel (0,0) in SDRAM.
REQ-004 SHALL have parameter FIFO_DEPTH, default 8, meaning output buffer entries (power of 2, >=4).
REQ-005 SHALL have port sys_clk  input  1  the single clock; every register updates on its rising edge.
REQ-006 SHALL have port sys_rst  input  1  reset, synchronous and active-high.
REQ-007 SHALL have port wshb_ifm  wshb_if.master  32-bit data  Wishbone master towards SDRAM.
REQ-008 SHALL have port pix_data  output  24  pixel RGB, taken from read word bits [23:0].
REQ-009 SHALL have port pix_valid  output  1  a buffered pixel is presented.
REQ-010 SHALL have port pix_ready  input  1  the consumer accepts the pixel.
REQ-011 SHALL have port pix_sof  output  1  the presented pixel is (0,0).
REQ-012 SHALL have port pix_eol  output  1  the presented pixel is at x=HDISP-1.

Function
REQ-013 SHALL perform Wishbone classic single reads only: we=0, sel=4'hF, cti=3'b000, bte=2'b00, dat_ms=0, cyc==stb.
REQ-014 SHALL raise stb at most one cycle after (fifo_count < FIFO_DEPTH) holds with no cycle in flight, and hold stb and adr stable until ack, err or rty.
REQ-015 SHALL drive adr = BASE_ADDR + 4*idx, where idx is the pixel index 0..HDISP*VDISP-1.
REQ-016 SHALL, on ack, push {dat_sm[23:0], sof=(x==0&&y==0), eol=(x==HDISP-1)} into the buffer and advance x/y/idx.
REQ-017 SHALL, on err, push pixel 24'h000000 with the correct flags and advance, so that the frame never stalls.
REQ-018 SHALL, on rty, push nothing and reissue the same address.
REQ-019 SHALL wrap x to 0 and increment y after x==HDISP-1, and wrap y and idx to 0 after the last pixel of the frame.
REQ-020 SHALL treat the stream side as a valid/ready handshake: pop when pix_valid&&pix_ready; pix_valid=(fifo_count!=0); data and flags stable while pix_valid&&!pix_ready.
REQ-021 SHALL keep fifo_count unchanged on a simultaneous push and pop, and SHALL never push when full or pop when empty.
REQ-022 SHALL use show-ahead outputs, so a pushed entry is visible one cycle after the push edge.
REQ-023 SHALL sustain one pixel per Wishbone ack and never lose or duplicate a pixel.

Reset
REQ-024 SHALL, while sys_rst=1, set cyc=stb=0, adr=BASE_ADDR, pix_valid=pix_sof=pix_eol=0, pix_data=0, empty the buffer and set x=y=idx=0.
REQ-025 SHALL, on reset asserted mid-cycle, drop cyc/stb at that edge and ignore any ack/err/rty arriving during or after reset for that cycle.
REQ-026 SHALL start the first read from (0,0) after reset is released.

Configuration
REQ-027 SHALL honour macro FRAME_READER_PATTERN_EN: when defined, cyc/stb are held at 0 and the buffer is filled internally at one entry per cycle while not full, with pixel {x[7:0], y[7:0], x[7:0]^y[7:0]} and identical sof/eol/wrap rules.
REQ-028 SHALL, without FRAME_READER_PATTERN_EN, behave exactly as REQ-013..REQ-023, with no pattern logic synthesized.

Structure
REQ-029 SHALL take pixel_t (24-bit RGB) and fifo entry struct {pixel_t data; sof; eol} from package frame_reader_pkg, which also holds WSHB_SEL_ALL and CTI_CLASSIC constants.
REQ-030 SHALL implement the buffer as sub-module pix_sync_fifo: single clock, parameterised depth, show-ahead, count output.

Verification
REQ-031 SHALL test HDISP=4, VDISP=2, BASE_ADDR=32'h100, slave acks each stb after 1 cycle, pix_ready=1 -> adr sequence 0x100,0x104..0x11C then 0x100; sof on pixel 0; eol on pixels 3 and 7.
REQ-032 SHALL test pix_ready=0 for 20 cycles -> exactly FIFO_DEPTH=8 acks then stb=0; pix_data and flags held; all 8 pixels are delivered in order on release.
REQ-033 SHALL test rty on address 0x108 once -> the next request reuses 0x108; stream shows no gap or duplicate.
REQ-034 SHALL test err on address 0x10C with dat_sm=32'hFFFFFFFF -> pixel 3 = 24'h000000 with eol=1; the next address is 0x110.
REQ-035 SHALL test sys_rst pulsed while stb=1 at adr 0x114 and ack arriving in the reset cycle -> pix_valid=0 and nothing pushed; the first post-reset adr is 0x100.
REQ-036 SHALL test FRAME_READER_PATTERN_EN defined -> cyc is never 1; pixel (2,1) = 24'h020103.
